// File: rtl/switch_ingress_pkg.sv
// switch_ingress_pkg: state encoding and packet-format constants shared by the ingress arbiter
package switch_ingress_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, TAG, LEN, PAYLOAD, GAP} state_e;
  localparam int OFS_ADDR = 0;
  localparam int OFS_TAG = 1;
  localparam int OFS_LEN = 2;
  localparam logic [7:0] PAD_BYTE = 8'h00;
endpackage

// File: rtl/switch_rr_pick.sv
// switch_rr_pick: combinational round-robin selector searching from rr_ptr+1 upward
module switch_rr_pick import switch_ingress_pkg::*; #(
  parameter int NUM_SRC = 4,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IW-1:0]      win,
  output logic               any
);
  always_comb begin
    gnt = '0;
    win = '0;
    any = |req;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_SRC]) begin
        gnt = '0;
        gnt[(int'(rr_ptr) + k) % NUM_SRC] = 1'b1;
        win = IW'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end
endmodule

// File: rtl/switch_ingress_arbiter.sv
// switch_ingress_arbiter: packet round-robin mux onto the switch ingress port; SWITCH_INGRESS_STALL_TIMEOUT_EN adds stall padding
module switch_ingress_arbiter import switch_ingress_pkg::*; #(
  parameter int NUM_SRC = 4,
  parameter int STALL_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_busy,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [NUM_SRC-1:0]   gnt,
  output logic [7:0]           data,
  output logic                 data_status,
  output logic                 pkt_done,
  output logic                 err_stall
);
  localparam int IW = $clog2(NUM_SRC);
  state_e state;
  logic [IW-1:0] rr_ptr, win;
  logic [NUM_SRC-1:0] pick;
  logic [7:0] remaining, byte_in;
  logic any, active, pad, xfer, last;
  switch_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (.req(src_req), .rr_ptr(rr_ptr), .gnt(pick), .win(win), .any(any));
  assign active = state inside {ADDR, TAG, LEN, PAYLOAD};
  assign src_ready = (active && !pad) ? gnt : '0;
  assign xfer = active && (pad || (src_valid[rr_ptr] && src_ready[rr_ptr]));
  assign byte_in = pad ? PAD_BYTE : src_data[{rr_ptr, 3'b000} +: 8];
  assign last = (state == LEN && byte_in == 8'h00) || (state == PAYLOAD && remaining == 8'd1);
  // rr_ptr doubles as the owner index while a packet is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= IW'(NUM_SRC - 1);
      remaining <= 8'h00;
      data <= 8'h00;
      data_status <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      data_status <= xfer;
      pkt_done <= xfer && last;
      if (xfer) data <= byte_in;
      case (state)
        IDLE: if (!cfg_busy && any) begin
          gnt <= pick;
          rr_ptr <= win;
          state <= ADDR;
        end
        ADDR: if (xfer) state <= TAG;
        TAG: if (xfer) state <= LEN;
        LEN: if (xfer) begin
          remaining <= byte_in;
          state <= (byte_in != 8'h00) ? PAYLOAD : GAP;
        end
        PAYLOAD: if (xfer) begin
          remaining <= remaining - 8'd1;
          state <= last ? GAP : PAYLOAD;
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (xfer && last) gnt <= '0;
    end
  end
`ifdef SWITCH_INGRESS_STALL_TIMEOUT_EN
  localparam int CW = $clog2(STALL_LIMIT + 1);
  logic [CW-1:0] stall_cnt;
  logic stall_hit;
  assign stall_hit = active && !pad && !xfer && stall_cnt == CW'(STALL_LIMIT - 1);
  // once padding starts it runs to the end of the packet; leaving the active states clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      pad <= 1'b0;
      err_stall <= 1'b0;
    end else begin
      err_stall <= stall_hit;
      pad <= active && (pad || stall_hit);
      stall_cnt <= (!active || pad || xfer || stall_hit) ? '0 : stall_cnt + 1'b1;
    end
  end
`else
  assign pad = 1'b0;
  assign err_stall = 1'b0;
`endif
endmodule

// File: tb/tb_switch_ingress_arbiter.sv
// tb_switch_ingress_arbiter: table vectors, directed corner sequences and randomized traffic against a packet-level model
module tb_switch_ingress_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_busy = 1'b0;
  logic [3:0] src_req = '0, src_valid = '0;
  logic [31:0] src_data = '0;
  logic [3:0] src_ready, gnt;
  logic [7:0] data;
  logic data_status, pkt_done, err_stall;

  switch_ingress_arbiter #(.NUM_SRC(4), .STALL_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .cfg_busy(cfg_busy), .src_req(src_req), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .gnt(gnt), .data(data),
    .data_status(data_status), .pkt_done(pkt_done), .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] vld;
    logic [7:0] b;
    logic [3:0] g;
    logic       ds;
    logic [7:0] d;
    logic       dn;
  } vec_t;

  int total = 0, bad = 0;
  logic [8:0] q[4][$];
  logic [3:0] req_en = '0, mid = '0, m_gnt = '0, prev_req = '0;
  logic prev_busy = 1'b0, m_ds = 1'b0, m_done = 1'b0, prev_done = 1'b0, seen_done = 1'b0;
  logic [7:0] m_data = 8'h00;
  int last_win = 3, vpct = 100, busy_pct = 0, since_done = 0, pkts_done = 0, added = 0;
  int order[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_next(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic add_pkt(int s, int len);
    q[s].push_back({1'b0, 8'($urandom)});
    q[s].push_back({1'b0, 8'(s)});
    q[s].push_back({len == 0, 8'(len)});
    for (int k = 0; k < len; k++) q[s].push_back({k == len - 1, 8'($urandom)});
    added++;
  endtask

  // one cycle: check outputs predicted last cycle, then drive and predict the next cycle
  task automatic step();
    logic [3:0] eg;
    logic [8:0] b;
    int w;
    @(negedge clk);
    if (m_gnt == 4'b0) begin
      w = rr_next(prev_req, last_win);
      eg = (!prev_done && !prev_busy && w >= 0) ? 4'(1 << w) : 4'b0;
      if (eg != 4'b0) begin
        last_win = w;
        order.push_back(w);
      end
    end else eg = m_done ? 4'b0 : m_gnt;
    m_gnt = eg;
    chk("gnt", gnt, eg);
    chk("src_ready", src_ready, eg);
    chk("data_status", data_status, m_ds);
    chk("data", data, m_data);
    chk("pkt_done", pkt_done, m_done);
    chk("err_stall", err_stall, 0);
    if (data_status) begin
      if (seen_done) chk("gap_idle", (since_done < 2) ? since_done : 2, 2);
      seen_done = 1'b0;
    end else since_done++;
    if (pkt_done) begin
      seen_done = 1'b1;
      since_done = 0;
    end
    prev_done = m_done;
    for (int i = 0; i < 4; i++) begin
      src_req[i] = req_en[i] && q[i].size() > 0;
      if (eg[i] && q[i].size() > 0) begin
        src_valid[i] = ($urandom % 100) < vpct;
        src_data[8*i +: 8] = q[i][0][7:0];
      end else begin
        src_valid[i] = 1'($urandom);
        src_data[8*i +: 8] = 8'($urandom);
      end
    end
    cfg_busy = ($urandom % 100) < busy_pct;
    prev_req = src_req;
    prev_busy = cfg_busy;
    m_ds = 1'b0;
    m_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (eg[i] && src_valid[i]) begin
        b = q[i].pop_front();
        m_ds = 1'b1;
        m_data = b[7:0];
        m_done = b[8];
        mid[i] = !b[8];
        if (b[8]) pkts_done++;
      end
    end
  endtask

  task automatic run_until(int target, int budget);
    for (int c = 0; c < budget && pkts_done < target; c++) step();
    chk("pkts_done", pkts_done, target);
  endtask

  task automatic do_reset();
    logic [8:0] b;
    @(negedge clk);
    rst = 1'b1;
    src_req = '0;
    src_valid = '0;
    cfg_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mid[i]) begin
        b = 9'h0;
        while (q[i].size() > 0 && !b[8]) b = q[i].pop_front();
      end
    end
    mid = '0;
    m_gnt = '0;
    m_ds = 1'b0;
    m_data = 8'h00;
    m_done = 1'b0;
    prev_done = 1'b0;
    prev_req = '0;
    prev_busy = 1'b0;
    last_win = 3;
    seen_done = 1'b0;
    since_done = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int base, n;
    tv[0] = '{4'b0001, 4'b0001, 8'hA5, 4'b0000, 1'b0, 8'h00, 1'b0};
    tv[1] = '{4'b0001, 4'b0001, 8'hA5, 4'b0001, 1'b0, 8'h00, 1'b0};
    tv[2] = '{4'b0001, 4'b0001, 8'h00, 4'b0001, 1'b1, 8'hA5, 1'b0};
    tv[3] = '{4'b0001, 4'b0001, 8'h02, 4'b0001, 1'b1, 8'h00, 1'b0};
    tv[4] = '{4'b0001, 4'b0001, 8'h11, 4'b0001, 1'b1, 8'h02, 1'b0};
    tv[5] = '{4'b0000, 4'b0001, 8'h22, 4'b0001, 1'b1, 8'h11, 1'b0};
    tv[6] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 8'h22, 1'b1};
    tv[7] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0, 8'h22, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", k), gnt, tv[k].g);
      chk($sformatf("vec%0d_ready", k), src_ready, tv[k].g);
      chk($sformatf("vec%0d_status", k), data_status, tv[k].ds);
      chk($sformatf("vec%0d_data", k), data, tv[k].d);
      chk($sformatf("vec%0d_done", k), pkt_done, tv[k].dn);
      src_req = tv[k].req;
      src_valid = tv[k].vld;
      src_data = {24'h0, tv[k].b};
    end
    do_reset();

    // four sources with header-only packets: strict rotation from source 0
    order.delete();
    add_pkt(0, 0); add_pkt(1, 0); add_pkt(2, 0); add_pkt(3, 0); add_pkt(0, 0);
    req_en = 4'hF;
    vpct = 100;
    busy_pct = 0;
    run_until(pkts_done + 5, 200);
    chk("rot_count", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) chk($sformatf("rot_order%0d", k), order[k], k % 4);

    // source 2 pauses three cycles mid-payload
    add_pkt(2, 4);
    for (int c = 0; c < 50 && q[2].size() > 2; c++) step();
    chk("pause_pos", q[2].size(), 2);
    vpct = 0;
    repeat (3) step();
    chk("pause_gnt", gnt, 4'b0100);
    vpct = 100;
    run_until(pkts_done + 1, 50);
    chk("pause_owner", order[$], 2);

    // cfg_busy gates new grants but not a packet in flight
    busy_pct = 100;
    add_pkt(3, 1);
    repeat (5) step();
    chk("busy_hold", gnt, 4'b0000);
    busy_pct = 0;
    step();
    step();
    chk("busy_release", gnt, 4'b1000);
    busy_pct = 100;
    run_until(pkts_done + 1, 50);
    busy_pct = 0;

    // reset during source 1 payload, then source 0 wins first
    add_pkt(1, 6);
    for (int c = 0; c < 50 && q[1].size() > 5; c++) step();
    chk("rst_pos", q[1].size(), 5);
    do_reset();
    step();
    chk("rst_data", data, 8'h00);
    base = order.size();
    for (int i = 0; i < 4; i++) add_pkt(i, 1);
    run_until(pkts_done + 4, 200);
    chk("rst_first_win", (order.size() > base) ? order[base] : -1, 0);

    // randomized traffic
    vpct = 70;
    busy_pct = 10;
    for (int c = 0; c < 1500; c++) begin
      req_en = 4'($urandom) | 4'b0001;
      if ($urandom % 100 < 8) begin
        n = $urandom % 4;
        if (q[n].size() < 40) add_pkt(n, $urandom % 7);
      end
      step();
    end
    req_en = 4'hF;
    vpct = 100;
    busy_pct = 0;
    for (int c = 0; c < 3000 && (q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0; c++) step();
    repeat (4) step();
    chk("drain_left", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    chk("drain_gnt", gnt, 4'b0000);

`ifdef SWITCH_INGRESS_STALL_TIMEOUT_EN
    begin
      logic [7:0] p1;
      do_reset();
      add_pkt(0, 3);
      req_en = 4'b0001;
      for (int c = 0; c < 50 && q[0].size() > 2; c++) step();
      chk("stall_pos", q[0].size(), 2);
      p1 = m_data;
      for (int c = 1; c <= 19; c++) begin
        @(negedge clk);
        chk($sformatf("stall%0d_status", c), data_status, (c == 1 || c >= 18) ? 1 : 0);
        chk($sformatf("stall%0d_data", c), data, (c >= 18) ? 8'h00 : p1);
        chk($sformatf("stall%0d_err", c), err_stall, (c == 17) ? 1 : 0);
        chk($sformatf("stall%0d_done", c), pkt_done, (c == 19) ? 1 : 0);
        chk($sformatf("stall%0d_gnt", c), gnt, (c < 19) ? 4'b0001 : 4'b0000);
        chk($sformatf("stall%0d_ready", c), src_ready, (c <= 16) ? 4'b0001 : 4'b0000);
        src_valid = '0;
        src_req = '0;
      end
      q[0].delete();
      mid = '0;
      do_reset();
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
